// File: rtl/sd_dac_8bit_if.sv
// Sample stream handshake into sd_dac_8bit: producer drives data/valid, DAC drives ready.
interface sd_dac_8bit_if #(
  parameter int unsigned BITS = 8
) ();
  logic [BITS-1:0] data;
  logic            valid;
  logic            ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sd_dac_8bit.sv
// First-order sigma-delta DAC: buffers codes in a small FIFO, releases one per sample
// period and modulates it into a 1-bit pulse-density stream (ones density = code / 2^BITS).
// Optional feature macro: SDDAC_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter.
module sd_dac_8bit #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RATE_DIV   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  sd_dac_8bit_if.slave                  in_bus,
  output logic                          dac_out,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef SDDAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_cnt
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(RATE_DIV);

  typedef enum logic {StIdle, StRun} state_e;

  logic [BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [CW-1:0]   cnt_q;
  logic [BITS-1:0] cur_q, acc_q;
  logic [BITS:0]   sum;
  state_e          state_q;
  logic            dac_q, underrun_q;
  logic            tick, empty, full, push, pop;

  assign tick  = (cnt_q == CW'(RATE_DIV - 1));
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(FIFO_DEPTH));
  // Both decisions use pre-edge occupancy, so a same-edge push never feeds a same-edge pop.
  assign push  = in_bus.valid & ~full;
  assign pop   = tick & ~empty;
  assign sum   = {1'b0, acc_q} + {1'b0, cur_q};

  assign in_bus.ready = ~full;
  assign level        = level_q;
  assign dac_out      = dac_q;
  assign underrun     = underrun_q;

  // Sample period counter, free-running 0..RATE_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_bus.data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Playback FSM: loads the current code on each tick and flags underruns once running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= BITS'(1) << (BITS - 1);
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            cur_q   <= mem[rd_ptr_q];
            state_q <= StRun;
          end
        end
        StRun: begin
          if (pop) begin
            cur_q <= mem[rd_ptr_q];
          end else if (tick) begin
            underrun_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Modulator: carry out of the accumulator is the output bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      dac_q <= 1'b0;
    end else begin
      acc_q <= sum[BITS-1:0];
      dac_q <= sum[BITS];
    end
  end

`ifdef SDDAC_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  assign underrun_cnt = ucnt_q;

  // Saturating count of underrun pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (underrun_q && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sd_dac_8bit.sv
// Self-checking bench for sd_dac_8bit: vector table, hand-written corner sequences and
// randomized traffic checked each cycle against a queue/arithmetic reference model.
module tb_sd_dac_8bit;
  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int RATE  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dac_out, underrun;
  logic [2:0] level;
`ifdef SDDAC_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  sd_dac_8bit_if #(.BITS(BITS)) bus ();

  sd_dac_8bit #(
    .BITS       (BITS),
    .FIFO_DEPTH (DEPTH),
    .RATE_DIV   (RATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_bus       (bus),
    .dac_out      (dac_out),
    .underrun     (underrun),
    .level        (level)
`ifdef SDDAC_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  int mq[$];
  int m_cnt, m_cur, m_acc, m_ucnt;
  bit m_run, m_dac, m_und;

  typedef struct {
    bit         valid;
    logic [7:0] data;
    int         exp_level;
    bit         exp_ready;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt  = 0;
    m_cur  = 1 << (BITS - 1);
    m_acc  = 0;
    m_run  = 1'b0;
    m_dac  = 1'b0;
    m_und  = 1'b0;
    m_ucnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dac_out"},  32'(dac_out),  32'(m_dac));
    check({tag, ".underrun"}, 32'(underrun), 32'(m_und));
    check({tag, ".level"},    32'(level),    32'(mq.size()));
    check({tag, ".in_ready"}, 32'(bus.ready), 32'(mq.size() != DEPTH));
`ifdef SDDAC_UNDERRUN_CNT_EN
    check({tag, ".underrun_cnt"}, 32'(underrun_cnt), 32'(m_ucnt));
`endif
  endtask

  // Advance model and DUT by one clock edge, then compare.
  task automatic step(input string tag = "model");
    int  sum, sz;
    bit  tick, push, pop;
    sz   = mq.size();
    tick = (m_cnt == RATE - 1);
    push = bus.valid && (sz < DEPTH);
    pop  = tick && (sz > 0);
    m_und = tick && (sz == 0) && m_run;
    if (m_und && m_ucnt < 65535) m_ucnt++;
    sum   = m_acc + m_cur;
    m_dac = (sum >= (1 << BITS));
    m_acc = sum % (1 << BITS);
    if (pop) begin
      m_cur = mq.pop_front();
      m_run = 1'b1;
    end
    if (push) mq.push_back(int'(bus.data));
    m_cnt = (m_cnt + 1) % RATE;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_one(input int d);
    bus.valid = 1'b1;
    bus.data  = 8'(d);
    step();
    bus.valid = 1'b0;
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic apply_reset();
    bus.valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ones, unds;

    tbl[0] = '{1'b1, 8'h11, 1, 1'b1};
    tbl[1] = '{1'b1, 8'h22, 2, 1'b1};
    tbl[2] = '{1'b1, 8'h33, 3, 1'b1};
    tbl[3] = '{1'b1, 8'h44, 4, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 4, 1'b0};
    tbl[5] = '{1'b0, 8'h66, 4, 1'b0};

    bus.valid = 1'b0;
    bus.data  = '0;

    // Idle after reset: midscale 0,1 pattern, never an underrun.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check("midscale", 32'(dac_out), 32'(i % 2));
    end
    unds = 0;
    for (int i = 0; i < 2 * RATE; i++) begin
      step();
      unds += int'(underrun);
    end
    check("idle_no_underrun", 32'(unds), 32'd0);

    // Back-to-back pushes with valid held: fourth fills, fifth is held off.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      bus.valid = tbl[i].valid;
      bus.data  = tbl[i].data;
      step("table");
      check("table.level", 32'(level), 32'(tbl[i].exp_level));
      check("table.ready", 32'(bus.ready), 32'(tbl[i].exp_ready));
    end
    bus.valid = 1'b0;
    run(RATE - 7);
    check("pre_tick_level", 32'(level), 32'd4);
    step();
    check("post_tick_level", 32'(level), 32'd3);
    check("post_tick_ready", 32'(bus.ready), 32'd1);

    // Code 0x40: 16 ones in every 64-cycle window once popped; RUN shows as underruns.
    apply_reset();
    push_one(8'h40);
    run(RATE - 1);
    unds = 0;
    for (int w = 0; w < 3; w++) begin
      ones = 0;
      for (int i = 0; i < RATE; i++) begin
        step();
        ones += int'(dac_out);
        unds += int'(underrun);
      end
      check("density_0x40", 32'(ones), 32'd16);
    end
    check("run_underruns", 32'(unds), 32'd3);

    // Code 0xFF then starvation: one-cycle underrun per tick, 255 ones per 256 cycles.
    apply_reset();
    push_one(8'hFF);
    run(RATE - 1);
    ones = 0;
    unds = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      ones += int'(dac_out);
      unds += int'(underrun);
      if (i == RATE - 2) check("ff_no_early_underrun", 32'(unds), 32'd0);
      if (i == RATE)     check("ff_single_pulse", 32'(unds), 32'd1);
    end
    check("density_0xFF", 32'(ones), 32'd255);
    check("ff_underruns", 32'(unds), 32'd4);

    // Reset mid-stream with code 0x20 playing and three samples queued.
    apply_reset();
    push_one(8'h20);
    run(RATE - 1);
    push_one(8'h01);
    push_one(8'h02);
    push_one(8'h03);
    run(10);
    check("pre_reset_level", 32'(level), 32'd3);
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_reset_mid", 32'(dac_out), 32'(i % 2));
    end
    unds = 0;
    for (int i = 0; i < 2 * RATE; i++) begin
      step();
      unds += int'(underrun);
    end
    check("post_reset_no_underrun", 32'(unds), 32'd0);

`ifdef SDDAC_UNDERRUN_CNT_EN
    // Underrun counter: three pulses, then saturation from a preloaded value.
    apply_reset();
    push_one(8'h10);
    run(RATE - 1);
    run(3 * RATE);
    check("ucnt_three", 32'(underrun_cnt), 32'd3);
    force dut.ucnt_q = 16'hFFFE;
    #1;
    release dut.ucnt_q;
    m_ucnt = 65534;
    run(3 * RATE);
    check("ucnt_saturated", 32'(underrun_cnt), 32'hFFFF);
`endif

    // Randomized traffic with phases of differing push rate and one reset mid-run.
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      int p;
      unique case ((i / 500) % 4)
        0:       p = 1;
        1:       p = 3;
        2:       p = 60;
        default: p = 97;
      endcase
      bus.valid = ($urandom_range(99) < 32'(p));
      bus.data  = 8'($urandom_range(255));
      if (i == 2100) apply_reset();
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
